// File: rtl/sound_request_arbiter.sv
// sound_request_arbiter: latches four sound request edges and sequences the single score player
// (select setup, trigger pulse, play window, gap). Optional preemption in PLAY: define SOUND_PREEMPT_EN.
module sound_request_arbiter #(
    parameter int unsigned SETUP_CYCLES    = 4,
    parameter int unsigned PULSE_CYCLES    = 500000,
    parameter int unsigned MAX_PLAY_CYCLES = 50000000,
    parameter int unsigned GAP_CYCLES      = 1000000,
    parameter int unsigned CNT_W           = 26
) (
    input  logic       Clock,
    input  logic       Reset,
    input  logic [3:0] Request,
    input  logic       Done,
    output logic [1:0] Choice,
    output logic       PlayAgain,
    output logic       Busy,
    output logic [3:0] Pending,
    output logic       Dropped
);

    localparam int unsigned REQ_W = 4;
    localparam int unsigned SEL_W = 2;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        SETUP = 3'd1,
        PULSE = 3'd2,
        PLAY  = 3'd3,
        GAP   = 3'd4
    } state_t;

    state_t             state;
    state_t             stateNext;
    logic [CNT_W-1:0]   count;
    logic [CNT_W-1:0]   countNext;
    logic [REQ_W-1:0]   requestQ;
    logic [REQ_W-1:0]   rise;
    logic [REQ_W-1:0]   clearMask;
    logic [REQ_W-1:0]   pendingNext;
    logic [SEL_W-1:0]   grantIdx;
    logic [SEL_W-1:0]   choiceNext;
    logic               grant;
    logic               playAgainNext;
    logic               droppedNext;
    logic               busyNext;

    // Highest set bit wins; bit 3 has top priority.
    function automatic logic [SEL_W-1:0] highestBit(input logic [REQ_W-1:0] v);
        logic [SEL_W-1:0] r;
        r = '0;
        for (int i = 0; i < int'(REQ_W); i++) begin
            if (v[i]) r = SEL_W'(i);
        end
        return r;
    endfunction

    // State, counter and all registered outputs.
    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            state     <= IDLE;
            count     <= '0;
            requestQ  <= '0;
            Choice    <= '0;
            PlayAgain <= 1'b0;
            Busy      <= 1'b0;
            Pending   <= '0;
            Dropped   <= 1'b0;
        end else begin
            state     <= stateNext;
            count     <= countNext;
            requestQ  <= Request;
            Choice    <= choiceNext;
            PlayAgain <= playAgainNext;
            Busy      <= busyNext;
            Pending   <= pendingNext;
            Dropped   <= droppedNext;
        end
    end

    // Next-state, grant and request bookkeeping.
    always_comb begin
        stateNext     = state;
        countNext     = (count != '0) ? count - CNT_W'(1) : '0;
        choiceNext    = Choice;
        playAgainNext = PlayAgain;
        grant         = 1'b0;
        rise          = Request & ~requestQ;
        grantIdx      = highestBit(Pending);

        case (state)
            IDLE: begin
                if (Pending != '0) begin
                    grant      = 1'b1;
                    choiceNext = grantIdx;
                    countNext  = CNT_W'(SETUP_CYCLES);
                    stateNext  = SETUP;
                end
            end
            SETUP: begin
                if (count == CNT_W'(1)) begin
                    playAgainNext = 1'b1;
                    countNext     = CNT_W'(PULSE_CYCLES);
                    stateNext     = PULSE;
                end
            end
            PULSE: begin
                if (count == CNT_W'(1)) begin
                    playAgainNext = 1'b0;
                    countNext     = CNT_W'(MAX_PLAY_CYCLES);
                    stateNext     = PLAY;
                end
            end
            PLAY: begin
                if (Done || count == CNT_W'(1)) begin
                    if (GAP_CYCLES == 0) begin
                        countNext = '0;
                        stateNext = IDLE;
                    end else begin
                        countNext = CNT_W'(GAP_CYCLES);
                        stateNext = GAP;
                    end
                end
`ifdef SOUND_PREEMPT_EN
                // A strictly higher request abandons the current sound and skips its gap.
                if (Pending != '0 && grantIdx > Choice) begin
                    grant      = 1'b1;
                    choiceNext = grantIdx;
                    countNext  = CNT_W'(SETUP_CYCLES);
                    stateNext  = SETUP;
                end
`endif
            end
            GAP: begin
                if (count == CNT_W'(1)) begin
                    countNext = '0;
                    stateNext = IDLE;
                end
            end
            default: begin
                countNext = '0;
                stateNext = IDLE;
            end
        endcase

        // A new edge on the granted bit re-arms it; only a surviving pending bit counts as a drop.
        clearMask   = grant ? (REQ_W'(1) << grantIdx) : '0;
        pendingNext = (Pending & ~clearMask) | rise;
        droppedNext = |(rise & Pending & ~clearMask);
        busyNext    = (stateNext != IDLE);
    end

endmodule

// File: tb/tb_sound_request_arbiter.sv
// Randomized scoreboard bench for sound_request_arbiter; reference model works on edge-number
// timelines of each granted sound rather than on a state machine.
module tb_sound_request_arbiter;

    localparam int S    = 2;
    localparam int P    = 3;
    localparam int MAXP = 20;
    localparam int GAPC = 4;

    logic       Clock = 1'b0;
    logic       Reset;
    logic [3:0] Request;
    logic       Done;
    logic [1:0] Choice;
    logic       PlayAgain;
    logic       Busy;
    logic [3:0] Pending;
    logic       Dropped;

    sound_request_arbiter #(
        .SETUP_CYCLES   (S),
        .PULSE_CYCLES   (P),
        .MAX_PLAY_CYCLES(MAXP),
        .GAP_CYCLES     (GAPC),
        .CNT_W          (8)
    ) dut (
        .Clock    (Clock),
        .Reset    (Reset),
        .Request  (Request),
        .Done     (Done),
        .Choice   (Choice),
        .PlayAgain(PlayAgain),
        .Busy     (Busy),
        .Pending  (Pending),
        .Dropped  (Dropped)
    );

    always #5 Clock = ~Clock;

    typedef struct packed {
        logic       busy;
        logic       playAgain;
        logic [1:0] choice;
        logic [3:0] pending;
        logic       dropped;
    } snap_t;

    snap_t      snapQ[$];
    logic [1:0] trigQ[$];
    int         tests = 0;
    int         fails = 0;

    // Reference model: each grant at edge G fixes the whole timeline of that sound.
    int         cyc = 0;
    logic [3:0] mPend;
    logic [3:0] mReqPrev;
    logic [1:0] mChoice;
    int         gEdge, playStart, endE, doneEdge, freeAt;
    bit         strayEn = 1'b0;

    function automatic int hiBit(input logic [3:0] v);
        int r;
        r = -1;
        for (int i = 0; i < 4; i++) if (v[i]) r = i;
        return r;
    endfunction

    task automatic modelReset();
        mPend     = '0;
        mReqPrev  = '0;
        mChoice   = '0;
        gEdge     = -1000;
        playStart = -1000;
        endE      = -1000;
        doneEdge  = -1000;
        freeAt    = 0;
        snapQ.delete();
        trigQ.delete();
    endtask

    task automatic modelStep();
        logic [3:0] rise, pendOld, clear;
        bit         doGrant;
        int         k, g, j;
        snap_t      s;
        cyc++;
        k        = cyc;
        rise     = Request & ~mReqPrev;
        mReqPrev = Request;
        pendOld  = mPend;
        clear    = '0;
        doGrant  = (k >= freeAt) && (pendOld != 0);
`ifdef SOUND_PREEMPT_EN
        if (k >= playStart && k <= endE && pendOld != 0 && hiBit(pendOld) > int'(mChoice)) doGrant = 1'b1;
`endif
        if (doGrant) begin
            g         = hiBit(pendOld);
            clear[g]  = 1'b1;
            mChoice   = 2'(g);
            gEdge     = k;
            j         = int'($urandom_range(1, MAXP + 4));
            playStart = k + S + P + 1;
            endE      = k + S + P + ((j < MAXP) ? j : MAXP);
            doneEdge  = (j <= MAXP) ? k + S + P + j : -1000;
            freeAt    = endE + GAPC + 1;
            trigQ.push_back(mChoice);
        end
        s.dropped   = |(rise & pendOld & ~clear);
        mPend       = (pendOld & ~clear) | rise;
        s.pending   = mPend;
        s.choice    = mChoice;
        s.busy      = (k + 1 < freeAt);
        s.playAgain = (k >= gEdge + S) && (k < gEdge + S + P);
        snapQ.push_back(s);
    endtask

    always @(posedge Clock) if (Reset === 1'b1) modelStep();

    // Monitor: compares every presented output cycle and every player trigger.
    snap_t monExp, monAct;
    logic  prevPA = 1'b0;
    always @(negedge Clock) begin
        if (Reset === 1'b1) begin
            if (snapQ.size() > 0) begin
                monExp = snapQ.pop_front();
                monAct = {Busy, PlayAgain, Choice, Pending, Dropped};
                tests++;
                if (monAct !== monExp) begin
                    fails++;
                    $display("FAIL outputs cyc=%0d got busy=%b pa=%b choice=%0d pend=%b drop=%b want busy=%b pa=%b choice=%0d pend=%b drop=%b",
                             cyc, monAct.busy, monAct.playAgain, monAct.choice, monAct.pending, monAct.dropped,
                             monExp.busy, monExp.playAgain, monExp.choice, monExp.pending, monExp.dropped);
                end
            end
            if (PlayAgain === 1'b1 && prevPA !== 1'b1) begin
                tests++;
                if (trigQ.size() == 0) begin
                    fails++;
                    $display("FAIL trigger cyc=%0d got unexpected PlayAgain rise choice=%0d want none", cyc, Choice);
                end else if (Choice !== trigQ[0]) begin
                    fails++;
                    $display("FAIL trigger cyc=%0d got choice=%0d want %0d", cyc, Choice, trigQ[0]);
                    void'(trigQ.pop_front());
                end else begin
                    void'(trigQ.pop_front());
                end
            end
            prevPA = PlayAgain;
        end else begin
            prevPA = 1'b0;
        end
    end

    task automatic chk(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s got %0d want %0d", name, act, exp);
        end
    endtask

    // One cycle of stimulus: Done follows the model's schedule plus optional stray pulses outside PLAY.
    task automatic tick();
        int nxt;
        @(negedge Clock);
        nxt  = cyc + 1;
        Done = (nxt == doneEdge) ||
               (strayEn && ($urandom_range(0, 9) == 0) && !(nxt >= playStart && nxt <= endE));
    endtask

    task automatic waitIdle(input int budget);
        int n;
        n = 0;
        while (!((cyc + 1 >= freeAt) && mPend == 0) && n < budget) begin
            tick();
            n++;
        end
        tick();
        chk("idle_wait_budget", int'(n < budget), 1);
    endtask

    task automatic waitPlay(input int budget);
        int n;
        n = 0;
        while (!(cyc + 1 >= playStart && cyc + 1 <= endE) && n < budget) begin
            tick();
            n++;
        end
        chk("play_wait_budget", int'(n < budget), 1);
    endtask

    task automatic pulseReq(input logic [3:0] v);
        Request = v;
        tick();
        Request = '0;
    endtask

    initial begin
        modelReset();
        Reset   = 1'b1;
        Request = '0;
        Done    = 1'b0;
        #1 Reset = 1'b0;
        #1;
        chk("reset_choice", int'(Choice), 0);
        chk("reset_playagain", int'(PlayAgain), 0);
        chk("reset_busy", int'(Busy), 0);
        chk("reset_pending", int'(Pending), 0);
        chk("reset_dropped", int'(Dropped), 0);
        repeat (2) @(negedge Clock);
        #2 Reset = 1'b1;

        // Single request, two simultaneous requests, then a drop and a higher request during PLAY.
        tick();
        pulseReq(4'b0001);
        waitIdle(200);
        pulseReq(4'b0011);
        waitIdle(200);
        pulseReq(4'b0001);
        waitPlay(50);
        pulseReq(4'b0100);
        tick();
        pulseReq(4'b0100);
        waitIdle(300);
        pulseReq(4'b0001);
        waitPlay(50);
        pulseReq(4'b1000);
        waitIdle(300);

        // Random request traffic with stray Done pulses outside PLAY.
        strayEn = 1'b1;
        for (int c = 0; c < 2000; c++) begin
            tick();
            if ($urandom_range(0, 5) == 0) Request[$urandom_range(0, 3)] ^= 1'b1;
        end

        // Reset asserted while the trigger pulse is high.
        begin
            int n;
            n = 0;
            Request = 4'b0000;
            tick();
            Request = 4'b1010;
            while (!(cyc >= gEdge + S && cyc < gEdge + S + P) && n < 300) begin
                tick();
                n++;
            end
            chk("pulse_wait_budget", int'(n < 300), 1);
            chk("pre_reset_playagain", int'(PlayAgain), 1);
            #2 Reset = 1'b0;
            modelReset();
            #1;
            chk("async_reset_playagain", int'(PlayAgain), 0);
            chk("async_reset_busy", int'(Busy), 0);
            chk("async_reset_pending", int'(Pending), 0);
            chk("async_reset_choice", int'(Choice), 0);
            repeat (2) @(negedge Clock);
            Done = 1'b0;
            #2 Reset = 1'b1;
        end

        // Bits still high at reset release count as fresh edges.
        for (int c = 0; c < 400; c++) begin
            tick();
            if ($urandom_range(0, 5) == 0) Request[$urandom_range(0, 3)] ^= 1'b1;
        end
        strayEn = 1'b0;
        Request = '0;
        waitIdle(1000);
        repeat (3) tick();
        chk("trigger_queue_drained", trigQ.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/sound_request_arbiter.md
Name: sound_request_arbiter

Overview:
- Shares the single music-score player (Choice select + PlayAgain trigger) among four game-event sound requesters (e.g. paddle hit, wall hit, point scored, game over).
- Latches request edges.
- Grants one request at a time by fixed priority.
- Sequences the player: select setup, trigger pulse held long enough to pass the player's debouncer, play window, inter-sound gap.
- Sits between game logic and the player.

Parameters:
- SETUP_CYCLES, 4: cycles Choice is held stable before PlayAgain rises; minimum 1.
- PULSE_CYCLES, 500000: cycles PlayAgain is held high; must exceed the debouncer's settle time; minimum 1.
- MAX_PLAY_CYCLES, 50000000: timeout for the play window if Done never arrives; minimum 1.
- GAP_CYCLES, 1000000: silent cycles after each sound before the next grant; 0 allowed.
- CNT_W, 26: width of the shared down-counter; must hold the largest parameter.

Ports:
- Clock, input, 1: system clock; all state changes on the rising edge.
- Reset, input, 1: asynchronous, active-low reset.
- Request, input, 4: level requests from game logic; a 0->1 transition on bit i registers one request for score i.
- Done, input, 1: end-of-score indication from the player, synchronous to Clock; only sampled in PLAY.
- Choice, output, 2: score select to the player.
- PlayAgain, output, 1: trigger to the player.
- Busy, output, 1: high in every state except IDLE.
- Pending, output, 4: latched, not-yet-granted requests.
- Dropped, output, 1: one-cycle pulse when a request edge arrives for a bit already pending.

Behaviour:
- Reset (asynchronous, Reset=0):
  - State=IDLE, Choice=0, PlayAgain=0, Busy=0, Pending=0, Dropped=0, counter=0.
  - The request edge-detect register is also cleared, so a Request bit that is already high when reset deasserts counts as one edge.
  - Reset asserted mid-sound aborts immediately; PlayAgain drops asynchronously.
- Edge capture: rise[i] = Request[i] and not Request_q[i], with Request_q registered every cycle.
  - On rise[i]: Pending[i] is set.
  - If Pending[i] was already 1 and is not cleared by a grant in the same cycle, Dropped pulses for one cycle (requests do not queue beyond depth 1).
- Priority: bit 3 is highest, bit 0 lowest. Grant index g = highest set bit of Pending.
- State machine (counter loads on state entry and decrements each cycle; a transition occurs when it reaches 1):
  - IDLE:
    - If Pending != 0: Choice<=g, Pending[g] cleared, counter<=SETUP_CYCLES, go to SETUP.
    - A rise on bit g in that same cycle re-sets Pending[g] (set wins over clear); Dropped is not pulsed.
  - SETUP: Choice held. After SETUP_CYCLES go to PULSE, PlayAgain<=1, counter<=PULSE_CYCLES.
  - PULSE: PlayAgain=1. After PULSE_CYCLES go to PLAY, PlayAgain<=0, counter<=MAX_PLAY_CYCLES.
  - PLAY:
    - Done=1, or counter expiry, leads to GAP with counter<=GAP_CYCLES.
    - If GAP_CYCLES=0, go straight to IDLE.
  - GAP: after GAP_CYCLES go to IDLE.
- Choice changes only on the IDLE->SETUP transition and holds its value until the next grant, including through IDLE.
- Done is ignored outside PLAY.
- Latency: from a rise in IDLE with Pending=0, Pending is visible the next cycle. The grant, and Choice becoming valid, follow one cycle after that. PlayAgain rises SETUP_CYCLES after the grant.
- Requests arriving during any non-IDLE state are latched and served in priority order after GAP.

Optional Feature:
- Macro: SOUND_PREEMPT_EN.
- Defined:
  - In PLAY, if the highest Pending bit is strictly higher than the currently playing Choice, the current sound is abandoned.
  - The new index is granted: Choice<=new index, Pending bit cleared, go to SETUP. The GAP is skipped.
  - The preempted request is not re-queued.
  - SETUP, PULSE and GAP are never preempted.
- Not defined: no preemption; a sound always completes PLAY and GAP.

Test Plan (SETUP=2, PULSE=3, MAX_PLAY=20, GAP=4):
- Single request:
  - Stimulus: Request=0001 rising in IDLE, Done pulsed 10 cycles after PlayAgain falls.
  - Response: Choice=0; PlayAgain high exactly 3 cycles, starting 2 cycles after the grant; Busy spans through GAP (4 cycles); Pending=0 at the end.
- Priority:
  - Stimulus: Request 0011 rises on the same cycle.
  - Response: Choice=1 is granted first, Pending=0001; Choice=0 follows after the first GAP.
- Timeout:
  - Stimulus: grant with Done held 0.
  - Response: PLAY lasts exactly 20 cycles, then GAP, then IDLE.
- Drop:
  - Stimulus: bit 2 rises, falls and rises again while Pending[2]=1 and a sound is in PLAY.
  - Response: Dropped pulses once; bit 2 plays only once afterwards.
- Reset mid-PULSE:
  - Stimulus: Reset=0 while PlayAgain=1.
  - Response: PlayAgain=0, Busy=0, Pending=0 immediately, without waiting for a clock edge.
- SOUND_PREEMPT_EN:
  - Stimulus: bit 3 rises during PLAY of Choice=0.
  - Response (macro defined): next cycle is SETUP with Choice=3, no GAP.
  - Response (macro undefined): Choice=3 is granted only after GAP completes.
